// File: rtl/snake_ctrl_pkg.sv
// Shared grid geometry, start positions and encodings for snake_ctrl.
// Imported by the controller and its bench.
package snake_ctrl_pkg;

    localparam int CW = 10;

    localparam logic [9:0] GRID_W = 10'd40;
    localparam logic [9:0] GRID_H = 10'd30;
    localparam logic [9:0] X_MIN  = 10'd1;
    localparam logic [9:0] X_MAX  = GRID_W - 10'd2;
    localparam logic [9:0] Y_MIN  = 10'd1;
    localparam logic [9:0] Y_MAX  = GRID_H - 10'd2;

    localparam logic [9:0] START_X  = 10'd20;
    localparam logic [9:0] START_Y  = 10'd15;
    localparam logic [9:0] APPLE_X0 = 10'd30;
    localparam logic [9:0] APPLE_Y0 = 10'd15;
    localparam logic [6:0] INIT_LEN = 7'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_SCAN   = 3'd2,
        S_UPDATE = 3'd3,
        S_APPLE  = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        D_UP    = 2'd0,
        D_DOWN  = 2'd1,
        D_LEFT  = 2'd2,
        D_RIGHT = 2'd3
    } dir_t;

    function automatic logic in_field(input logic [9:0] x,
                                      input logic [9:0] y);
        return (x >= X_MIN) && (x <= X_MAX) &&
               (y >= Y_MIN) && (y <= Y_MAX);
    endfunction

    function automatic logic [9:0] init_x(input int i);
        return (i < 3) ? START_X - 10'(i) : 10'd0;
    endfunction

    function automatic logic [9:0] init_y(input int i);
        return (i < 3) ? START_Y : 10'd0;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
// Loads the seed on reset and steps whenever enabled.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    // shift right, fold the output bit back through the tap mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= i_seed;
        else if (i_en)
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? 16'hB400 : 16'h0000);
    end

    assign o_q = r_q;

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller: tick-paced movement, self-collision scan,
// growth on apple and LFSR-driven apple placement.
module snake_ctrl
    import snake_ctrl_pkg::*;
#(
    parameter int SNAKE_MAX = 64,
    parameter int TICK_DIV  = 12_500_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      start,
    output logic [10*SNAKE_MAX-1:0]   snake_x,
    output logic [10*SNAKE_MAX-1:0]   snake_y,
    output logic [6:0]                snake_length,
    output logic [9:0]                apple_x,
    output logic [9:0]                apple_y,
    output logic                      game_over,
    output logic [7:0]                score
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (SNAKE_MAX > 1) ? $clog2(SNAKE_MAX) : 1;

    state_t          r_state, w_state_nxt;
    dir_t            r_dir;
    logic [TW-1:0]   r_tick;
    logic [9:0]      r_sx [SNAKE_MAX];
    logic [9:0]      r_sy [SNAKE_MAX];
    logic [6:0]      r_len;
    logic [7:0]      r_score;
    logic [9:0]      r_ax, r_ay;
    logic [9:0]      r_nx, r_ny;
    logic [6:0]      r_idx;
    logic            r_go;

    logic [15:0]     w_lfsr;
    logic [9:0]      w_cx, w_cy;
    logic [9:0]      w_apx, w_apy;
    logic [6:0]      w_len_nxt;
    logic [IW-1:0]   w_sidx;
    logic            w_term, w_hit, w_last, w_eat, w_apple_ok, w_reload;
    logic            w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (1'b1),
        .i_seed (LFSR_SEED),
        .o_q    (w_lfsr)
    );

    assign w_apx      = {4'd0, w_lfsr[5:0]};
    assign w_apy      = {5'd0, w_lfsr[12:8]};
    assign w_apple_ok = in_field(w_apx, w_apy);
    assign w_unused_lfsr = ^{w_lfsr[15:13], w_lfsr[7:6]};

    assign w_term   = (r_state == S_RUN) && (r_tick == TW'(TICK_DIV - 1));
    assign w_sidx   = r_idx[IW-1:0];
    assign w_hit    = (r_sx[w_sidx] == r_nx) && (r_sy[w_sidx] == r_ny);
    assign w_last   = (r_idx == r_len - 7'd2);
    assign w_eat    = (r_nx == r_ax) && (r_ny == r_ay);
    assign w_reload = (r_state == S_OVER) && start;
    assign w_len_nxt = (w_eat && (r_len < 7'(SNAKE_MAX))) ? r_len + 7'd1 : r_len;

    // candidate head one cell ahead of the current head
    always_comb begin
        w_cx = r_sx[0];
        w_cy = r_sy[0];
        case (r_dir)
            D_UP:    w_cy = r_sy[0] - 10'd1;
            D_DOWN:  w_cy = r_sy[0] + 10'd1;
            D_LEFT:  w_cx = r_sx[0] - 10'd1;
            default: w_cx = r_sx[0] + 10'd1;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_RUN;
            S_RUN:    if (w_term)
                          w_state_nxt = in_field(w_cx, w_cy) ? S_SCAN : S_OVER;
            S_SCAN:   if (w_hit)
                          w_state_nxt = S_OVER;
                      else if (w_last)
                          w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = w_eat ? S_APPLE : S_RUN;
            S_APPLE:  if (w_apple_ok) w_state_nxt = S_RUN;
            S_OVER:   if (start) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // move-step tick counter, only advancing while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick <= '0;
        else if (w_reload || w_term)
            r_tick <= '0;
        else if (r_state == S_RUN)
            r_tick <= r_tick + TW'(1);
    end

    // direction latch: first non-reversing request wins, up>down>left>right
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dir <= D_RIGHT;
        else if (w_reload)
            r_dir <= D_RIGHT;
        else if (r_state == S_RUN) begin
            if (btn_up && r_dir != D_DOWN)
                r_dir <= D_UP;
            else if (btn_down && r_dir != D_UP)
                r_dir <= D_DOWN;
            else if (btn_left && r_dir != D_RIGHT)
                r_dir <= D_LEFT;
            else if (btn_right && r_dir != D_LEFT)
                r_dir <= D_RIGHT;
        end
    end

    // next-head latch and scan pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nx  <= '0;
            r_ny  <= '0;
            r_idx <= '0;
        end else if (w_term) begin
            r_nx  <= w_cx;
            r_ny  <= w_cy;
            r_idx <= '0;
        end else if (r_state == S_SCAN) begin
            r_idx <= r_idx + 7'd1;
        end
    end

    // body shift, growth and score on a committed move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SNAKE_MAX; i++) begin
                r_sx[i] <= init_x(i);
                r_sy[i] <= init_y(i);
            end
            r_len   <= INIT_LEN;
            r_score <= 8'd0;
        end else if (w_reload) begin
            for (int i = 0; i < SNAKE_MAX; i++) begin
                r_sx[i] <= init_x(i);
                r_sy[i] <= init_y(i);
            end
            r_len   <= INIT_LEN;
            r_score <= 8'd0;
        end else if (r_state == S_UPDATE) begin
            r_sx[0] <= r_nx;
            r_sy[0] <= r_ny;
            for (int i = 1; i < SNAKE_MAX; i++) begin
                r_sx[i] <= (7'(i) < w_len_nxt) ? r_sx[i-1] : 10'd0;
                r_sy[i] <= (7'(i) < w_len_nxt) ? r_sy[i-1] : 10'd0;
            end
            r_len <= w_len_nxt;
            if (w_eat && r_score != 8'hFF)
                r_score <= r_score + 8'd1;
        end
    end

    // apple position, reseeded from the LFSR after each meal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ax <= APPLE_X0;
            r_ay <= APPLE_Y0;
        end else if (w_reload) begin
            r_ax <= APPLE_X0;
            r_ay <= APPLE_Y0;
        end else if (r_state == S_APPLE && w_apple_ok) begin
            r_ax <= w_apx;
            r_ay <= w_apy;
        end
    end

    // game-over flag tracks entry into and exit from OVER
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_go <= 1'b0;
        else
            r_go <= (w_state_nxt == S_OVER);
    end

    // flatten segment registers onto the output buses
    always_comb begin
        snake_x = '0;
        snake_y = '0;
        for (int i = 0; i < SNAKE_MAX; i++) begin
            snake_x[i*10 +: 10] = r_sx[i];
            snake_y[i*10 +: 10] = r_sy[i];
        end
    end

    assign snake_length = r_len;
    assign apple_x      = r_ax;
    assign apple_y      = r_ay;
    assign game_over    = r_go;
    assign score        = r_score;

endmodule
